trig_emul: RTL and testbench

TRIG_EMUL -- requirements
Module: trig_emul

---
 rtl/trig_emul_pkg.sv | 16 +
 rtl/trig_emul_sat_cnt.sv | 28 ++
 rtl/trig_emul.sv | 170 +++++++++++++++++
 tb/tb_trig_emul.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/trig_emul_pkg.sv
// Shared definitions for the trigger emulator: FSM state encoding and default widths.
package trig_emul_pkg;

    localparam int DEF_LAT_W = 10;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LCT  = 3'd1,
        S_WAIT = 3'd2,
        S_L1A  = 3'd3,
        S_GAP  = 3'd4,
        S_FIN  = 3'd5
    } state_t;

endpackage

// File: rtl/trig_emul_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear beats increment).
module sat_cnt
    import trig_emul_pkg::*;
#(
    parameter int W = DEF_CNT_W
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + W'(1);
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/trig_emul.sv
// LCT/L1A burst generator with match/no-match response counters.
module trig_emul
    import trig_emul_pkg::*;
#(
    parameter int LAT_W = DEF_LAT_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             ABORT,
    input  logic [LAT_W-1:0] LATENCY,
    input  logic [CNT_W-1:0] NTRIG,
    input  logic [CNT_W-1:0] GAP,
    input  logic             SKIP_L1A,
    input  logic             MATCH_IN,
    input  logic             NOMATCH_IN,
    output logic             LCT,
    output logic             L1A,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] SENT_CNT,
    output logic [CNT_W-1:0] MATCH_CNT,
    output logic [CNT_W-1:0] NOMATCH_CNT
);

    localparam int DW = (LAT_W > CNT_W) ? LAT_W : CNT_W;

    state_t           state_reg;
    logic [LAT_W-1:0] lat_reg;
    logic [CNT_W-1:0] ntrig_reg;
    logic [CNT_W-1:0] gap_reg;
    logic             skip_reg;
    logic [DW-1:0]    dcnt_reg;
    logic [CNT_W-1:0] sent_reg;
    logic             lct_reg;
    logic             l1a_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [DW-1:0]    lat_ext;
    logic [DW-1:0]    gap_ext;
    logic             start_acc;

    assign lat_ext   = DW'(lat_reg);
    assign gap_ext   = DW'(gap_reg);
    assign start_acc = START && (state_reg == S_IDLE) && !ABORT;

    // WAIT and GAP are skipped when their length would be zero, so LATENCY<=1
    // and GAP=0 still give the required back-to-back slot timing.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= S_IDLE;
            lat_reg   <= '0;
            ntrig_reg <= '0;
            gap_reg   <= '0;
            skip_reg  <= 1'b0;
            dcnt_reg  <= '0;
            sent_reg  <= '0;
            lct_reg   <= 1'b0;
            l1a_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else if (ABORT) begin
            state_reg <= S_IDLE;
            lct_reg   <= 1'b0;
            l1a_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            lct_reg  <= 1'b0;
            l1a_reg  <= 1'b0;
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (START) begin
                        lat_reg   <= LATENCY;
                        ntrig_reg <= NTRIG;
                        gap_reg   <= GAP;
                        skip_reg  <= SKIP_L1A;
                        if (NTRIG == '0) begin
                            sent_reg  <= '0;
                            state_reg <= S_FIN;
                            done_reg  <= 1'b1;
                        end else begin
                            sent_reg  <= CNT_W'(1);
                            state_reg <= S_LCT;
                            lct_reg   <= 1'b1;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                S_LCT: begin
                    if (lat_reg <= LAT_W'(1)) begin
                        state_reg <= S_L1A;
                        l1a_reg   <= !skip_reg;
                    end else begin
                        state_reg <= S_WAIT;
                        dcnt_reg  <= lat_ext - DW'(2);
                    end
                end
                S_WAIT: begin
                    if (dcnt_reg == '0) begin
                        state_reg <= S_L1A;
                        l1a_reg   <= !skip_reg;
                    end else begin
                        dcnt_reg <= dcnt_reg - DW'(1);
                    end
                end
                S_L1A: begin
                    if (sent_reg == ntrig_reg) begin
                        state_reg <= S_FIN;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                    end else if (gap_reg == '0) begin
                        state_reg <= S_LCT;
                        lct_reg   <= 1'b1;
                        sent_reg  <= sent_reg + CNT_W'(1);
                    end else begin
                        state_reg <= S_GAP;
                        dcnt_reg  <= gap_ext - DW'(1);
                    end
                end
                S_GAP: begin
                    if (dcnt_reg == '0) begin
                        state_reg <= S_LCT;
                        lct_reg   <= 1'b1;
                        sent_reg  <= sent_reg + CNT_W'(1);
                    end else begin
                        dcnt_reg <= dcnt_reg - DW'(1);
                    end
                end
                S_FIN: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Response counters: index 0 counts MATCH_IN, index 1 counts NOMATCH_IN.
    logic [1:0]       resp_pulse;
    logic [CNT_W-1:0] resp_cnt [2];

    assign resp_pulse = {NOMATCH_IN, MATCH_IN};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            sat_cnt #(.W(CNT_W)) u_cnt (
                .CLK (CLK),
                .RST (RST),
                .clr (start_acc),
                .inc (resp_pulse[gi] && !ABORT),
                .cnt (resp_cnt[gi])
            );
        end
    endgenerate

    assign LCT         = lct_reg;
    assign L1A         = l1a_reg;
    assign BUSY        = busy_reg;
    assign DONE        = done_reg;
    assign SENT_CNT    = sent_reg;
    assign MATCH_CNT   = resp_cnt[0];
    assign NOMATCH_CNT = resp_cnt[1];

endmodule

// File: tb/tb_trig_emul.sv
// Directed bench for trig_emul: burst timing, skip, zero-length, abort, reset and saturation.
module tb_trig_emul;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic       ABORT = 1'b0;
    logic [9:0] LATENCY = '0;
    logic [7:0] NTRIG = '0;
    logic [7:0] GAP = '0;
    logic       SKIP_L1A = 1'b0;
    logic       MATCH_IN;
    logic       NOMATCH_IN = 1'b0;
    logic       LCT, L1A, BUSY, DONE;
    logic [7:0] SENT_CNT, MATCH_CNT, NOMATCH_CNT;

    logic model_en = 1'b0;
    logic model_match = 1'b0;
    logic man_match = 1'b0;

    int n_tests = 0;
    int n_fail = 0;
    int lct_q[$];
    int l1a_q[$];
    int done_q[$];
    bit busy_v [0:1023];
    int busy_n;
    int cnt;

    assign MATCH_IN = model_match | man_match;

    always #5 CLK = ~CLK;

    trig_emul dut (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
        .LATENCY(LATENCY), .NTRIG(NTRIG), .GAP(GAP), .SKIP_L1A(SKIP_L1A),
        .MATCH_IN(MATCH_IN), .NOMATCH_IN(NOMATCH_IN),
        .LCT(LCT), .L1A(L1A), .BUSY(BUSY), .DONE(DONE),
        .SENT_CNT(SENT_CNT), .MATCH_CNT(MATCH_CNT), .NOMATCH_CNT(NOMATCH_CNT)
    );

    // Receiving trigger register: answers each L1A with a match pulse.
    always @(negedge CLK) model_match = model_en & L1A;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // START is high during cycle 0; outputs are sampled on the falling edge of cycles 1..ncyc.
    task automatic run(input int lat, input int n, input int gap, input int skip,
                       input int ncyc, input int rs, input int ab);
        lct_q.delete(); l1a_q.delete(); done_q.delete(); busy_n = 0;
        @(negedge CLK);
        LATENCY = 10'(lat); NTRIG = 8'(n); GAP = 8'(gap); SKIP_L1A = skip[0]; START = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge CLK);
            START = 1'b0; ABORT = 1'b0;
            if (LCT)  lct_q.push_back(c);
            if (L1A)  l1a_q.push_back(c);
            if (DONE) done_q.push_back(c);
            busy_v[c] = BUSY;
            if (BUSY) busy_n++;
            if (c == rs) begin NTRIG = 8'd5; LATENCY = 10'd1; START = 1'b1; end
            if (c == ab) ABORT = 1'b1;
        end
        START = 1'b0; ABORT = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        check("rst_lct", int'(LCT), 0);
        check("rst_busy", int'(BUSY), 0);
        check("rst_sent", int'(SENT_CNT), 0);
        check("rst_match", int'(MATCH_CNT), 0);
        RST = 1'b0;

        run(5, 3, 2, 0, 30, -1, -1);
        $display("[TB] burst lat=5 n=3 gap=2: lct=%p l1a=%p done=%p sent=%0d", lct_q, l1a_q, done_q, SENT_CNT);
        check("b1_nlct", lct_q.size(), 3);
        check("b1_lct0", qget(lct_q, 0), 1);
        check("b1_lct1", qget(lct_q, 1), 9);
        check("b1_lct2", qget(lct_q, 2), 17);
        check("b1_l1a0", qget(l1a_q, 0), 6);
        check("b1_l1a1", qget(l1a_q, 1), 14);
        check("b1_l1a2", qget(l1a_q, 2), 22);
        check("b1_done", qget(done_q, 0), 23);
        check("b1_ndone", done_q.size(), 1);
        check("b1_busy22", int'(busy_v[22]), 1);
        check("b1_busy23", int'(busy_v[23]), 0);
        check("b1_sent", int'(SENT_CNT), 3);

        run(0, 2, 0, 0, 10, -1, -1);
        $display("[TB] burst lat=0 n=2 gap=0: lct=%p l1a=%p done=%p", lct_q, l1a_q, done_q);
        check("b2_lct0", qget(lct_q, 0), 1);
        check("b2_lct1", qget(lct_q, 1), 3);
        check("b2_l1a0", qget(l1a_q, 0), 2);
        check("b2_l1a1", qget(l1a_q, 1), 4);
        check("b2_done", qget(done_q, 0), 5);

        run(4, 2, 1, 1, 16, -1, -1);
        $display("[TB] skip lat=4 n=2 gap=1: lct=%p l1a=%p done=%p", lct_q, l1a_q, done_q);
        check("b3_lct0", qget(lct_q, 0), 1);
        check("b3_lct1", qget(lct_q, 1), 7);
        check("b3_nl1a", l1a_q.size(), 0);
        check("b3_done", qget(done_q, 0), 12);

        run(2, 2, 0, 0, 12, 2, -1);
        $display("[TB] start-while-busy lat=2 n=2: lct=%p l1a=%p done=%p sent=%0d", lct_q, l1a_q, done_q, SENT_CNT);
        check("b4_nlct", lct_q.size(), 2);
        check("b4_lct1", qget(lct_q, 1), 4);
        check("b4_l1a1", qget(l1a_q, 1), 6);
        check("b4_done", qget(done_q, 0), 7);

        run(3, 0, 1, 0, 5, -1, -1);
        $display("[TB] ntrig=0: lct=%p done=%p busy_cycles=%0d", lct_q, done_q, busy_n);
        check("b5_done", qget(done_q, 0), 1);
        check("b5_nlct", lct_q.size(), 0);
        check("b5_busy", busy_n, 0);

        run(5, 4, 1, 0, 30, -1, 10);
        $display("[TB] abort n=4: lct=%p l1a=%p done=%p sent=%0d", lct_q, l1a_q, done_q, SENT_CNT);
        check("ab_nlct", lct_q.size(), 2);
        check("ab_nl1a", l1a_q.size(), 1);
        check("ab_ndone", done_q.size(), 0);
        check("ab_busy10", int'(busy_v[10]), 1);
        check("ab_busy11", int'(busy_v[11]), 0);
        check("ab_sent", int'(SENT_CNT), 2);

        model_en = 1'b1;
        run(1, 200, 0, 0, 405, -1, -1);
        model_en = 1'b0;
        $display("[TB] looped burst n=200: match_cnt=%0d", MATCH_CNT);
        check("m_200", int'(MATCH_CNT), 200);
        repeat (100) begin
            @(negedge CLK) man_match = 1'b1;
            @(negedge CLK) man_match = 1'b0;
        end
        $display("[TB] after 300 match pulses: match_cnt=%0d", MATCH_CNT);
        check("m_sat", int'(MATCH_CNT), 255);
        check("nm_zero", int'(NOMATCH_CNT), 0);
        repeat (3) begin
            @(negedge CLK) NOMATCH_IN = 1'b1;
            @(negedge CLK) NOMATCH_IN = 1'b0;
        end
        check("nm_3", int'(NOMATCH_CNT), 3);
        run(1, 0, 0, 0, 3, -1, -1);
        $display("[TB] new start: match_cnt=%0d nomatch_cnt=%0d", MATCH_CNT, NOMATCH_CNT);
        check("m_clr", int'(MATCH_CNT), 0);
        check("nm_clr", int'(NOMATCH_CNT), 0);
        repeat (2) begin
            @(negedge CLK) man_match = 1'b1;
            @(negedge CLK) man_match = 1'b0;
        end
        check("m_2", int'(MATCH_CNT), 2);
        @(negedge CLK);
        NTRIG = 8'd0; START = 1'b1; man_match = 1'b1;
        @(negedge CLK);
        START = 1'b0; man_match = 1'b0;
        @(negedge CLK);
        $display("[TB] match coincident with clear: match_cnt=%0d", MATCH_CNT);
        check("m_clrwin", int'(MATCH_CNT), 0);

        @(negedge CLK);
        LATENCY = 10'd2; NTRIG = 8'd3; GAP = 8'd4; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (4) @(negedge CLK);
        check("r_busy_pre", int'(BUSY), 1);
        RST = 1'b1;
        #1;
        $display("[TB] reset mid-gap: lct=%0d l1a=%0d busy=%0d done=%0d sent=%0d", LCT, L1A, BUSY, DONE, SENT_CNT);
        check("r_lct", int'(LCT), 0);
        check("r_l1a", int'(L1A), 0);
        check("r_busy", int'(BUSY), 0);
        check("r_done", int'(DONE), 0);
        check("r_sent", int'(SENT_CNT), 0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        cnt = 0;
        repeat (12) begin
            @(negedge CLK);
            if (LCT || L1A) cnt++;
        end
        check("r_quiet", cnt, 0);
        run(2, 0, 0, 0, 4, -1, -1);
        $display("[TB] post-reset ntrig=0: lct=%p done=%p", lct_q, done_q);
        check("r_done1", qget(done_q, 0), 1);
        check("r_nlct", lct_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
